// File: rtl/snake_pkg.sv
// Shared snake-game types: state encoding, BCD digit type and bus widths.
// Imported by the length counter and the display side.
package snake_pkg;

  localparam int LEN_W = 7;
  localparam int BCD_W = 8;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD,
    S_WIN
  } state_e;

  // Elaboration-time binary to packed 2-digit BCD
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    return {bcd_digit_t'(v / 10), bcd_digit_t'(v % 10)};
  endfunction

endpackage

// File: rtl/snake_len_ctr_if.sv
// Game-event inputs and length/state outputs of the snake length counter.
// The counter takes the slave side; the game logic or bench takes master.
interface snake_len_ctr_if;
  import snake_pkg::*;

  logic             start;
  logic             eat;
  logic             crash;
  logic [BCD_W-1:0] snake_length;
  logic [LEN_W-1:0] len_bin;
  logic             playing;
  logic             game_over;
  logic             win;

  modport master (
    output start,
    output eat,
    output crash,
    input  snake_length,
    input  len_bin,
    input  playing,
    input  game_over,
    input  win
  );

  modport slave (
    input  start,
    input  eat,
    input  crash,
    output snake_length,
    output len_bin,
    output playing,
    output game_over,
    output win
  );

endinterface

// File: rtl/bcd2_incr.sv
// Combinational increment of a packed 2-digit BCD value.
// carry_o is set only when 99 wraps to 00.
module bcd2_incr
  import snake_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             carry_o
);

  bcd_digit_t units;
  bcd_digit_t tens;
  bcd_digit_t units_d;
  bcd_digit_t tens_d;
  logic       u_carry;

  assign units = bcd_i[3:0];
  assign tens  = bcd_i[7:4];

  always_comb begin
    units_d = units + 4'd1;
    u_carry = 1'b0;
    if (units == 4'd9) begin
      units_d = 4'd0;
      u_carry = 1'b1;
    end
  end

  always_comb begin
    tens_d  = tens;
    carry_o = 1'b0;
    if (u_carry) begin
      if (tens == 4'd9) begin
        tens_d  = 4'd0;
        carry_o = 1'b1;
      end else begin
        tens_d = tens + 4'd1;
      end
    end
  end

  assign bcd_o = {tens_d, units_d};

endmodule

// File: rtl/snake_len_ctr.sv
// Snake length counter: BCD + binary length, eat edge detect and the
// IDLE/RUN/DEAD/WIN game FSM. All outputs come straight from registers.
module snake_len_ctr
  import snake_pkg::*;
#(
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 99
) (
  input logic            clk,
  input logic            rst,
  snake_len_ctr_if.slave bus
);

  localparam logic [BCD_W-1:0] INIT_BCD = to_bcd(INIT_LEN);
  localparam logic [LEN_W-1:0] INIT_BIN = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] MAX_BIN  = LEN_W'(MAX_LEN);

  state_e           state_q;
  logic [BCD_W-1:0] len_bcd_q;
  logic [LEN_W-1:0] len_bin_q;
  logic             eat_q;
  logic             playing_q;
  logic             game_over_q;
  logic             win_q;

  logic [BCD_W-1:0] bcd_inc_d;
  logic [LEN_W-1:0] bin_inc_d;
  logic             bcd_carry;
  logic             eat_ev;
  logic             win_hit;

  bcd2_incr u_incr (
    .bcd_i   (len_bcd_q),
    .bcd_o   (bcd_inc_d),
    .carry_o (bcd_carry)
  );

  assign bin_inc_d = len_bin_q + LEN_W'(1);
  assign eat_ev    = bus.eat & ~eat_q;
  // BCD wrap can never be a legal next length, so treat it as a win too
  assign win_hit   = (bin_inc_d == MAX_BIN) | bcd_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_bcd_q   <= INIT_BCD;
      len_bin_q   <= INIT_BIN;
      eat_q       <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      eat_q <= bus.eat;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_RUN;
            len_bcd_q <= INIT_BCD;
            len_bin_q <= INIT_BIN;
            playing_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.start) begin
            len_bcd_q <= INIT_BCD;
            len_bin_q <= INIT_BIN;
          end else if (bus.crash) begin
            state_q     <= S_DEAD;
            playing_q   <= 1'b0;
            game_over_q <= 1'b1;
          end else if (eat_ev) begin
            len_bcd_q <= bcd_inc_d;
            len_bin_q <= bin_inc_d;
            if (win_hit) begin
              state_q   <= S_WIN;
              playing_q <= 1'b0;
              win_q     <= 1'b1;
            end
          end
        end
        S_DEAD, S_WIN: begin
          if (bus.start) begin
            state_q     <= S_RUN;
            len_bcd_q   <= INIT_BCD;
            len_bin_q   <= INIT_BIN;
            playing_q   <= 1'b1;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.snake_length = len_bcd_q;
  assign bus.len_bin      = len_bin_q;
  assign bus.playing      = playing_q;
  assign bus.game_over    = game_over_q;
  assign bus.win          = win_q;

endmodule

// File: tb/tb_snake_len_ctr.sv
// Bench for snake_len_ctr (MAX_LEN 99 and 12 side by side) and bcd2_incr.
// A game-rule model tracks both counters; directed and random scenarios.
module tb_snake_len_ctr;

  logic clk;
  logic rst;
  logic start;
  logic eat;
  logic crash;

  int total;
  int bad;

  snake_len_ctr_if if99();
  snake_len_ctr_if if12();

  assign if99.start = start;
  assign if99.eat   = eat;
  assign if99.crash = crash;
  assign if12.start = start;
  assign if12.eat   = eat;
  assign if12.crash = crash;

  snake_len_ctr #(.INIT_LEN(3), .MAX_LEN(99)) dut99 (
    .clk (clk),
    .rst (rst),
    .bus (if99)
  );

  snake_len_ctr #(.INIT_LEN(3), .MAX_LEN(12)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (if12)
  );

  logic [7:0] inc_in;
  logic [7:0] inc_out;
  logic       inc_cy;

  bcd2_incr u_inc (
    .bcd_i   (inc_in),
    .bcd_o   (inc_out),
    .carry_o (inc_cy)
  );

  logic [7:0] sl[2];
  logic [6:0] lb[2];
  logic       pl[2];
  logic       go[2];
  logic       wn[2];

  assign sl[0] = if99.snake_length;
  assign lb[0] = if99.len_bin;
  assign pl[0] = if99.playing;
  assign go[0] = if99.game_over;
  assign wn[0] = if99.win;
  assign sl[1] = if12.snake_length;
  assign lb[1] = if12.len_bin;
  assign pl[1] = if12.playing;
  assign go[1] = if12.game_over;
  assign wn[1] = if12.win;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Game-rule model: 0 idle, 1 running, 2 dead, 3 won
  int m_st[2];
  int m_len[2];
  int m_max[2] = '{99, 12};
  bit m_prev;

  function automatic logic [7:0] to_bcd8(input int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic tick();
    bit ev;
    @(posedge clk);
    ev = eat && !m_prev;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_st[k]  = 0;
        m_len[k] = 3;
      end else if (m_st[k] == 1) begin
        if (start) m_len[k] = 3;
        else if (crash) m_st[k] = 2;
        else if (ev) begin
          m_len[k] = m_len[k] + 1;
          if (m_len[k] == m_max[k]) m_st[k] = 3;
        end
      end else if (start) begin
        m_st[k]  = 1;
        m_len[k] = 3;
      end
    end
    m_prev = rst ? 1'b0 : eat;
    #1;
  endtask

  task automatic eats(input int n);
    for (int i = 0; i < n; i++) begin
      eat = 1'b1;
      tick();
      eat = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; eat = 1'b0; crash = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (sl[k] !== 8'h03 || lb[k] !== 7'd3) begin
        bad++;
        $display("FAIL reset_len[%0d] got=%h/%0d exp=03/3", k, sl[k], lb[k]);
      end
      total++;
      if ({pl[k], go[k], wn[k]} !== 3'b000) begin
        bad++;
        $display("FAIL reset_flags[%0d] got=%b exp=000", k, {pl[k], go[k], wn[k]});
      end
    end
  endtask

  task automatic test_start_eats();
    eat = 1'b1;
    tick();
    eat = 1'b0;
    tick();
    total++;
    if (sl[0] !== 8'h03 || pl[0] !== 1'b0) begin
      bad++;
      $display("FAIL idle_ignores_eat got=%h/%b exp=03/0", sl[0], pl[0]);
    end
    pulse_start();
    total++;
    if (sl[0] !== 8'h03 || lb[0] !== 7'd3 || pl[0] !== 1'b1) begin
      bad++;
      $display("FAIL start got=%h/%0d/%b exp=03/3/1", sl[0], lb[0], pl[0]);
    end
    eats(5);
    total++;
    if (sl[0] !== 8'h08 || lb[0] !== 7'd8) begin
      bad++;
      $display("FAIL five_eats got=%h/%0d exp=08/8", sl[0], lb[0]);
    end
  endtask

  task automatic test_carry();
    eats(1);
    eat = 1'b1;
    tick();
    total++;
    if (sl[0] !== 8'h10 || lb[0] !== 7'd10) begin
      bad++;
      $display("FAIL carry_9_10 got=%h/%0d exp=10/10", sl[0], lb[0]);
    end
    eat = 1'b0;
    tick();
    eats(9);
    total++;
    if (sl[0] !== 8'h19) begin
      bad++;
      $display("FAIL at_19 got=%h exp=19", sl[0]);
    end
    eats(1);
    total++;
    if (sl[0] !== 8'h20 || lb[0] !== 7'd20) begin
      bad++;
      $display("FAIL carry_19_20 got=%h/%0d exp=20/20", sl[0], lb[0]);
    end
  endtask

  task automatic test_hold();
    eat = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    eat = 1'b0;
    tick();
    total++;
    if (sl[0] !== 8'h21 || lb[0] !== 7'd21) begin
      bad++;
      $display("FAIL eat_held got=%h/%0d exp=21/21", sl[0], lb[0]);
    end
  endtask

  task automatic test_eat_crash();
    eat = 1'b1;
    crash = 1'b1;
    tick();
    eat = 1'b0;
    crash = 1'b0;
    total++;
    if (sl[0] !== 8'h21 || go[0] !== 1'b1 || pl[0] !== 1'b0) begin
      bad++;
      $display("FAIL eat_crash got=%h go=%b pl=%b exp=21 go=1 pl=0", sl[0], go[0], pl[0]);
    end
    eats(2);
    total++;
    if (sl[0] !== 8'h21 || go[0] !== 1'b1) begin
      bad++;
      $display("FAIL dead_frozen got=%h go=%b exp=21 go=1", sl[0], go[0]);
    end
  endtask

  task automatic test_dead_restart();
    pulse_start();
    eats(24);
    crash = 1'b1;
    tick();
    crash = 1'b0;
    total++;
    if (sl[0] !== 8'h27 || go[0] !== 1'b1) begin
      bad++;
      $display("FAIL dead_27 got=%h go=%b exp=27 go=1", sl[0], go[0]);
    end
    pulse_start();
    total++;
    if (sl[0] !== 8'h03 || pl[0] !== 1'b1 || go[0] !== 1'b0) begin
      bad++;
      $display("FAIL dead_restart got=%h pl=%b go=%b exp=03 1 0", sl[0], pl[0], go[0]);
    end
  endtask

  task automatic test_rst_mid();
    eats(42);
    total++;
    if (sl[0] !== 8'h45 || pl[0] !== 1'b1) begin
      bad++;
      $display("FAIL at_45 got=%h pl=%b exp=45 1", sl[0], pl[0]);
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    total++;
    if (sl[0] !== 8'h03 || lb[0] !== 7'd3 || {pl[0], go[0], wn[0]} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid got=%h/%0d flags=%b exp=03/3 000",
               sl[0], lb[0], {pl[0], go[0], wn[0]});
    end
  endtask

  task automatic test_win12();
    pulse_start();
    eats(8);
    total++;
    if (sl[1] !== 8'h11 || pl[1] !== 1'b1) begin
      bad++;
      $display("FAIL m12_at_11 got=%h pl=%b exp=11 1", sl[1], pl[1]);
    end
    eat = 1'b1;
    tick();
    total++;
    if (sl[1] !== 8'h12 || wn[1] !== 1'b1 || pl[1] !== 1'b0) begin
      bad++;
      $display("FAIL m12_win got=%h win=%b pl=%b exp=12 1 0", sl[1], wn[1], pl[1]);
    end
    eat = 1'b0;
    tick();
    eats(3);
    total++;
    if (sl[1] !== 8'h12 || lb[1] !== 7'd12 || wn[1] !== 1'b1) begin
      bad++;
      $display("FAIL m12_hold got=%h/%0d win=%b exp=12/12 1", sl[1], lb[1], wn[1]);
    end
    total++;
    if (sl[0] !== 8'h15 || pl[0] !== 1'b1) begin
      bad++;
      $display("FAIL m99_side got=%h pl=%b exp=15 1", sl[0], pl[0]);
    end
  endtask

  task automatic test_win99();
    pulse_start();
    eats(96);
    total++;
    if (sl[0] !== 8'h99 || lb[0] !== 7'd99 || wn[0] !== 1'b1 || pl[0] !== 1'b0) begin
      bad++;
      $display("FAIL m99_win got=%h/%0d win=%b pl=%b exp=99/99 1 0",
               sl[0], lb[0], wn[0], pl[0]);
    end
    eats(2);
    total++;
    if (sl[0] !== 8'h99 || lb[0] !== 7'd99) begin
      bad++;
      $display("FAIL m99_cap got=%h/%0d exp=99/99", sl[0], lb[0]);
    end
  endtask

  task automatic test_random();
    int tens_v;
    int units_v;
    pulse_start();
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 79) == 0);
      crash = ($urandom_range(0, 99) == 0);
      eat   = ($urandom_range(0, 1) == 1);
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (sl[k] !== to_bcd8(m_len[k]) || lb[k] !== 7'(m_len[k])) begin
          bad++;
          $display("FAIL rnd_len[%0d] cyc=%0d got=%h/%0d exp=%h/%0d",
                   k, i, sl[k], lb[k], to_bcd8(m_len[k]), m_len[k]);
        end
        total++;
        if (pl[k] !== (m_st[k] == 1) || go[k] !== (m_st[k] == 2) ||
            wn[k] !== (m_st[k] == 3)) begin
          bad++;
          $display("FAIL rnd_flags[%0d] cyc=%0d got=%b%b%b st=%0d",
                   k, i, pl[k], go[k], wn[k], m_st[k]);
        end
        tens_v  = int'(sl[k][7:4]);
        units_v = int'(sl[k][3:0]);
        total++;
        if (tens_v > 9 || units_v > 9 || tens_v * 10 + units_v != int'(lb[k])) begin
          bad++;
          $display("FAIL rnd_agree[%0d] cyc=%0d bcd=%h bin=%0d", k, i, sl[k], lb[k]);
        end
      end
    end
    start = 1'b0;
    crash = 1'b0;
    eat   = 1'b0;
    tick();
  endtask

  task automatic test_bcd_exhaustive();
    for (int v = 0; v < 99; v++) begin
      inc_in = to_bcd8(v);
      #1;
      total++;
      if (inc_out !== to_bcd8(v + 1) || inc_cy !== 1'b0) begin
        bad++;
        $display("FAIL bcd_inc in=%h got=%h cy=%b exp=%h cy=0",
                 inc_in, inc_out, inc_cy, to_bcd8(v + 1));
      end
    end
    inc_in = 8'h99;
    #1;
    total++;
    if (inc_out !== 8'h00 || inc_cy !== 1'b1) begin
      bad++;
      $display("FAIL bcd_wrap got=%h cy=%b exp=00 cy=1", inc_out, inc_cy);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    m_prev = 1'b0;
    inc_in = 8'h00;
    test_reset();
    test_start_eats();
    test_carry();
    test_hold();
    test_eat_crash();
    test_dead_restart();
    test_rst_mid();
    test_win12();
    test_win99();
    test_random();
    test_bcd_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
